// File: rtl/joust2_audio_pkg.sv
// Shared types and helpers for the joust2 stereo audio mixer: sample widths,
// input normalisation, gain weighting and 16-bit saturation.
package joust2_audio_pkg;

  localparam int unsigned MIX_W  = 21;
  localparam int unsigned DC_W   = 24;
  localparam int unsigned TERM_W = 19;

  typedef logic signed [MIX_W-1:0]  mix_t;
  typedef logic signed [DC_W-1:0]   dc_t;
  typedef logic signed [TERM_W-1:0] term_t;
  typedef logic signed [15:0]       pcm_t;

  typedef struct packed {
    logic [15:0] val;
    logic        clip;
  } sat_t;

  localparam dc_t PCM_MAX = 24'sd32767;
  localparam dc_t PCM_MIN = -24'sd32768;

  function automatic pcm_t norm_dac(input logic [7:0] d);
    return {~d[7], d[6:0], 8'h00};
  endfunction

  function automatic pcm_t norm_speech(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

  function automatic term_t gain_term(input pcm_t n, input logic [2:0] g);
    term_t ext;
    term_t gs;
    ext = n;
    gs  = term_t'({16'b0, g});
    return ext * gs;
  endfunction

  function automatic sat_t sat16(input dc_t y);
    sat_t r;
    if (y > PCM_MAX) begin
      r.val  = 16'h7FFF;
      r.clip = 1'b1;
    end else if (y < PCM_MIN) begin
      r.val  = 16'h8000;
      r.clip = 1'b1;
    end else begin
      r.val  = y[15:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/joust2_audio_chan.sv
// One mixer channel: adds its FM term to the shared DAC/speech mix, box-car
// averages over the window, applies the DC blocker and saturates to 16 bits.
module joust2_audio_chan
  import joust2_audio_pkg::*;
#(
  parameter int unsigned LOG2_DIV = 8,
  parameter int unsigned GAIN_FM  = 1,
  parameter int unsigned DC_K     = 10
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        win_done,
  input  logic        dc_load,
  input  logic        dc_en,
  input  mix_t        shared_mix,
  input  logic [15:0] fm,
  output logic [15:0] sat_val,
  output logic        sat_clip
);

  localparam int unsigned ACC_W = MIX_W + LOG2_DIV;
  typedef logic signed [ACC_W-1:0] acc_t;

  mix_t mix;
  mix_t avg;
  mix_t avg_next;
  acc_t acc;
  acc_t acc_sum;
  dc_t  avg_ext;
  dc_t  x_prev;
  dc_t  y_prev;
  dc_t  y;
  sat_t sat;

  always_comb begin
    mix      = shared_mix + mix_t'(gain_term(pcm_t'(fm), 3'(GAIN_FM)));
    acc_sum  = acc + acc_t'(mix);
    avg_next = mix_t'(acc_sum >>> LOG2_DIV);
    avg_ext  = dc_t'(avg);
    if (dc_en)
      y = avg_ext - x_prev + y_prev - (y_prev >>> DC_K);
    else
      y = avg_ext;
    sat      = sat16(y);
    sat_val  = sat.val;
    sat_clip = sat.clip;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      avg    <= '0;
      x_prev <= '0;
      y_prev <= '0;
    end else begin
      if (win_done) begin
        acc <= '0;
        avg <= avg_next;
      end else begin
        acc <= acc_sum;
      end
      // history keeps tracking in bypass so enabling dc_en later starts clean
      if (dc_load) begin
        x_prev <= avg_ext;
        y_prev <= y;
      end
    end
  end

endmodule

// File: rtl/joust2_audio_mixer.sv
// Decimating, gain-weighted stereo mixer feeding the emu audio pins with
// signed 16-bit PCM at clk_sys / 2^LOG2_DIV.
module joust2_audio_mixer
  import joust2_audio_pkg::*;
#(
  parameter int unsigned LOG2_DIV    = 8,
  parameter int unsigned GAIN_DAC    = 2,
  parameter int unsigned GAIN_SPEECH = 1,
  parameter int unsigned GAIN_FM     = 1,
  parameter int unsigned DC_K        = 10
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [7:0]         audio_1,
  input  logic [7:0]         audio_2,
  input  logic [15:0]        speech,
  input  logic [15:0]        ym2151_left,
  input  logic [15:0]        ym2151_right,
  input  logic               mute,
  input  logic               dc_en,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               sample_stb,
  output logic               clip
);

  logic [LOG2_DIV-1:0] cnt;
  logic                win_done;
  logic                win_d1;
  mix_t                shared_mix;
  logic [15:0]         sat_l;
  logic [15:0]         sat_r;
  logic                clip_l;
  logic                clip_r;

  always_comb begin
    shared_mix = mix_t'(gain_term(norm_dac(audio_1), 3'(GAIN_DAC)))
               + mix_t'(gain_term(norm_dac(audio_2), 3'(GAIN_DAC)))
               + mix_t'(gain_term(norm_speech(speech), 3'(GAIN_SPEECH)));
    win_done   = (cnt == '1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      win_d1     <= 1'b0;
      sample_stb <= 1'b0;
      clip       <= 1'b0;
      audio_l    <= '0;
      audio_r    <= '0;
    end else begin
      cnt        <= cnt + LOG2_DIV'(1);
      win_d1     <= win_done;
      sample_stb <= win_d1;
      clip       <= win_d1 & (clip_l | clip_r);
      if (win_d1) begin
        audio_l <= mute ? '0 : sat_l;
        audio_r <= mute ? '0 : sat_r;
      end
    end
  end

  joust2_audio_chan #(
    .LOG2_DIV (LOG2_DIV),
    .GAIN_FM  (GAIN_FM),
    .DC_K     (DC_K)
  ) u_chan_l (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .win_done   (win_done),
    .dc_load    (win_d1),
    .dc_en      (dc_en),
    .shared_mix (shared_mix),
    .fm         (ym2151_left),
    .sat_val    (sat_l),
    .sat_clip   (clip_l)
  );

  joust2_audio_chan #(
    .LOG2_DIV (LOG2_DIV),
    .GAIN_FM  (GAIN_FM),
    .DC_K     (DC_K)
  ) u_chan_r (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .win_done   (win_done),
    .dc_load    (win_d1),
    .dc_en      (dc_en),
    .shared_mix (shared_mix),
    .fm         (ym2151_right),
    .sat_val    (sat_r),
    .sat_clip   (clip_r)
  );

endmodule

// File: tb/tb_joust2_audio_mixer.sv
// Directed bench for joust2_audio_mixer: vector table of steady mixes plus
// sequences for mute, alternating input, mid-window reset and DC decay.
module tb_joust2_audio_mixer;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [7:0]         audio_1;
  logic [7:0]         audio_2;
  logic [15:0]        speech;
  logic [15:0]        ym2151_left;
  logic [15:0]        ym2151_right;
  logic               mute;
  logic               dc_en;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic               sample_stb;
  logic               clip;

  int checks = 0;
  int errors = 0;
  int stray_clip = 0;

  always #5 clk_sys = ~clk_sys;

  joust2_audio_mixer #(
    .LOG2_DIV    (8),
    .GAIN_DAC    (2),
    .GAIN_SPEECH (1),
    .GAIN_FM     (1),
    .DC_K        (10)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .audio_1      (audio_1),
    .audio_2      (audio_2),
    .speech       (speech),
    .ym2151_left  (ym2151_left),
    .ym2151_right (ym2151_right),
    .mute         (mute),
    .dc_en        (dc_en),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .sample_stb   (sample_stb),
    .clip         (clip)
  );

  typedef struct {
    string       name;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] sp;
    logic [15:0] yl;
    logic [15:0] yr;
    int          el;
    int          er;
    int          ec;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // waits for the next strobe (sampled at negedge); n = negedges waited
  task automatic wait_stb(output int n);
    bit got;
    got = 0;
    n = 0;
    while (!got && n < 600) begin
      @(negedge clk_sys);
      n++;
      if (sample_stb) got = 1;
      else if (clip) stray_clip++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL stb_timeout actual=no_strobe required=strobe_within_600");
    end
  endtask

  task automatic silence();
    audio_1 = 8'h80; audio_2 = 8'h80; speech = 16'h8000;
    ym2151_left = 16'h0000; ym2151_right = 16'h0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int xp, yp, y, prev;

    vecs[0]  = '{"silent",    8'h80, 8'h80, 16'h8000, 16'h0000, 16'h0000, 0,      0,      0};
    vecs[1]  = '{"fm1000",    8'h80, 8'h80, 16'h8000, 16'd1000, 16'h0000, 1000,   0,      0};
    vecs[2]  = '{"all_max",   8'hFF, 8'hFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 32767,  32767,  1};
    vecs[3]  = '{"all_min",   8'h00, 8'h00, 16'h0000, 16'h8000, 16'h8000, -32768, -32768, 1};
    vecs[4]  = '{"fm_lr",     8'h80, 8'h80, 16'h8000, 16'hFC18, 16'h01F4, -1000,  500,    0};
    vecs[5]  = '{"dac1_pos",  8'hA0, 8'h80, 16'h8000, 16'h0000, 16'h0000, 16384,  16384,  0};
    vecs[6]  = '{"speech",    8'h80, 8'h80, 16'h9000, 16'h0000, 16'h0000, 4096,   4096,   0};
    vecs[7]  = '{"dac2_neg",  8'h80, 8'h70, 16'h8000, 16'h0000, 16'h0000, -8192,  -8192,  0};
    vecs[8]  = '{"edge_hi",   8'h80, 8'h80, 16'h8000, 16'h7FFF, 16'h0000, 32767,  0,      0};
    vecs[9]  = '{"over_hi",   8'h80, 8'h80, 16'h8001, 16'h7FFF, 16'h0000, 32767,  1,      1};
    vecs[10] = '{"edge_lo",   8'h80, 8'h80, 16'h8000, 16'h8000, 16'h8000, -32768, -32768, 0};
    vecs[11] = '{"under_lo",  8'h80, 8'h80, 16'h7FFF, 16'h8000, 16'h0000, -32768, -1,     1};
    vecs[12] = '{"mixed",     8'h90, 8'h60, 16'h8100, 16'h0064, 16'hFF38, -7836,  -8136,  0};

    silence();
    mute = 1'b0;
    dc_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_audio_l", int'(audio_l), 0);
    check("rst_audio_r", int'(audio_r), 0);
    check("rst_stb", int'(sample_stb), 0);
    check("rst_clip", int'(clip), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;

    // silent inputs: first strobe after the full window plus 2-cycle latency
    wait_stb(n);
    check("first_stb_latency", n, 257);
    check("silent_l", int'(audio_l), 0);
    check("silent_r", int'(audio_r), 0);
    for (int i = 0; i < 3; i++) begin
      wait_stb(n);
      check("stb_period", n, 256);
      check("silent_l_hold", int'(audio_l), 0);
    end

    for (int i = 0; i < 13; i++) begin
      audio_1 = vecs[i].a1; audio_2 = vecs[i].a2; speech = vecs[i].sp;
      ym2151_left = vecs[i].yl; ym2151_right = vecs[i].yr;
      wait_stb(n);
      wait_stb(n);
      check({vecs[i].name, "_l"}, int'(audio_l), vecs[i].el);
      check({vecs[i].name, "_r"}, int'(audio_r), vecs[i].er);
      check({vecs[i].name, "_clip"}, int'(clip), vecs[i].ec);
      wait_stb(n);
      check({vecs[i].name, "_period"}, n, 256);
      check({vecs[i].name, "_l_again"}, int'(audio_l), vecs[i].el);
    end

    // mute forces zero at the output register only
    silence();
    ym2151_left = 16'd1000;
    mute = 1'b1;
    wait_stb(n);
    wait_stb(n);
    check("mute_l", int'(audio_l), 0);
    mute = 1'b0;
    wait_stb(n);
    check("unmute_l", int'(audio_l), 1000);

    // alternating DAC every cycle averages to (-32768+32512)*2/2
    silence();
    audio_1 = 8'h00;
    fork
      begin
        repeat (900) begin
          @(negedge clk_sys);
          audio_1 = ~audio_1;
        end
      end
      begin
        wait_stb(n);
        wait_stb(n);
        check("alt_l", int'(audio_l), -256);
        check("alt_r", int'(audio_r), -256);
        wait_stb(n);
        check("alt_l_stable", int'(audio_l), -256);
        check("alt_r_stable", int'(audio_r), -256);
      end
    join
    silence();

    // reset at cnt=100 with a large input; the partial window must vanish
    ym2151_left = 16'd30000;
    ym2151_right = 16'hFFFF - 16'd29999;
    wait_stb(n);
    wait_stb(n);
    check("pre_rst_l", int'(audio_l), 30000);
    check("pre_rst_r", int'(audio_r), -30000);
    repeat (99) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("midrst_l", int'(audio_l), 0);
    check("midrst_r", int'(audio_r), 0);
    check("midrst_stb", int'(sample_stb), 0);
    repeat (3) @(negedge clk_sys);
    silence();
    reset_n = 1'b1;
    wait_stb(n);
    check("midrst_latency", n, 257);
    check("midrst_first_l", int'(audio_l), 0);
    check("midrst_first_r", int'(audio_r), 0);

    // DC blocker step response: 0 -> 8000, checked against the leaky recurrence
    reset_n = 1'b0;
    dc_en = 1'b1;
    silence();
    ym2151_left = 16'd8000;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    xp = 0; yp = 0; prev = 8000;
    for (int k = 0; k < 64; k++) begin
      wait_stb(n);
      y = 8000 - xp + yp - (yp >>> 10);
      xp = 8000;
      yp = y;
      check("dc_step_l", int'(audio_l), y);
      check("dc_monotonic", int'(int'(audio_l) <= prev), 1);
      check("dc_nonneg", int'(int'(audio_l) >= 0), 1);
      prev = int'(audio_l);
    end
    check("dc_first_equals_step", int'(8000 - (8000 >>> 10)) - 8000 + 8000, 7993);
    check("dc_r_quiet", int'(audio_r), 0);
    check("dc_decayed", int'(int'(audio_l) < 8000), 1);
    check("stray_clip", stray_clip, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
